// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and its datapath/memory.
// The controller takes the master side; the datapath observes through the slave side.
interface multicycle_controller_if #(
  parameter int CNT_W = 16
);
  logic [6:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             PCWrite;
  logic             AdrSrc;
  logic             MemRead;
  logic             MemWrite;
  logic             IRWrite;
  logic [1:0]       ResultSrc;
  logic [1:0]       ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUOp;
  logic             RegWrite;
  logic             Branch;
  logic             illegal_op;
  logic             instr_done;
  logic [CNT_W-1:0] retired_cnt;
  logic [3:0]       state;

  modport master (
    input  opcode, zero, mem_ready,
    output PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, ResultSrc, ALUSrcA,
           ALUSrcB, ALUOp, RegWrite, Branch, illegal_op, instr_done,
           retired_cnt, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, ResultSrc, ALUSrcA,
           ALUSrcB, ALUOp, RegWrite, Branch, illegal_op, instr_done,
           retired_cnt, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RISC-V datapath: sequences each instruction,
// waits on memory, flags illegal opcodes and counts retired instructions.
module multicycle_controller #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit SUPPORT_JAL   = 1'b1,
  parameter int CNT_W         = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  multicycle_controller_if.master io_bus
);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_retired;

  logic       w_ready;
  logic       w_pc_update;
  logic       w_pcwrite;
  logic       w_adr_src;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_reg_write;
  logic       w_branch;
  logic       w_illegal;
  logic       w_done;
  logic [1:0] w_result_src;
  logic [1:0] w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_alu_op;

  assign w_ready = MEM_HANDSHAKE ? io_bus.mem_ready : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_done) r_retired <= r_retired + CNT_W'(1);
    end
  end

  always_comb begin
    w_next       = S_FETCH;
    w_pc_update  = 1'b0;
    w_adr_src    = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_branch     = 1'b0;
    w_illegal    = 1'b0;
    w_done       = 1'b0;
    w_result_src = 2'b00;
    w_alu_src_a  = 2'b00;
    w_alu_src_b  = 2'b00;
    w_alu_op     = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_mem_read   = 1'b1;
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
        w_ir_write   = w_ready;
        w_pc_update  = w_ready;
        if (w_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b01;
        case (io_bus.opcode)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_RTYPE:          w_next = S_EXECR;
          OP_ITYPE:          w_next = S_EXECI;
          OP_BEQ:            w_next = S_BEQ;
          OP_JAL: begin
            if (SUPPORT_JAL) w_next = S_JAL;
            else             w_illegal = 1'b1;
          end
          default:           w_illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        // IR is stable here, so the opcode alone picks load versus store
        w_next      = (io_bus.opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        w_adr_src  = 1'b1;
        w_mem_read = 1'b1;
        w_next     = w_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        w_result_src = 2'b01;
        w_reg_write  = 1'b1;
        w_done       = 1'b1;
      end
      S_MEMWRITE: begin
        w_adr_src   = 1'b1;
        w_mem_write = 1'b1;
        w_done      = w_ready;
        w_next      = w_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        w_alu_src_a = 2'b10;
        w_alu_op    = 2'b10;
        w_next      = S_ALUWB;
      end
      S_EXECI: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        w_alu_op    = 2'b10;
        w_next      = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_done      = 1'b1;
      end
      S_BEQ: begin
        w_alu_src_a = 2'b10;
        w_alu_op    = 2'b01;
        w_branch    = 1'b1;
        w_done      = 1'b1;
      end
      S_JAL: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b10;
        w_pc_update = 1'b1;
        w_next      = S_ALUWB;
      end
      default: w_next = S_FETCH;
    endcase
  end

  assign w_pcwrite = w_pc_update | (w_branch & io_bus.zero);

  // Every strobe is held low while reset is asserted, independent of state decode
  assign io_bus.PCWrite     = rst_n & w_pcwrite;
  assign io_bus.AdrSrc      = rst_n & w_adr_src;
  assign io_bus.MemRead     = rst_n & w_mem_read;
  assign io_bus.MemWrite    = rst_n & w_mem_write;
  assign io_bus.IRWrite     = rst_n & w_ir_write;
  assign io_bus.RegWrite    = rst_n & w_reg_write;
  assign io_bus.Branch      = rst_n & w_branch;
  assign io_bus.illegal_op  = rst_n & w_illegal;
  assign io_bus.instr_done  = rst_n & w_done;
  assign io_bus.ResultSrc   = rst_n ? w_result_src : 2'b00;
  assign io_bus.ALUSrcA     = rst_n ? w_alu_src_a  : 2'b00;
  assign io_bus.ALUSrcB     = rst_n ? w_alu_src_b  : 2'b00;
  assign io_bus.ALUOp       = rst_n ? w_alu_op     : 2'b00;
  assign io_bus.state       = r_state;
  assign io_bus.retired_cnt = r_retired;
endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: instruction table with a scoreboard on DUT A
// (handshake + JAL, 4-bit counter) and hand sequences on DUT B (no handshake, no JAL).
module tb_multicycle_controller;
  logic clk = 1'b0;
  logic rst_a_n = 1'b1;
  logic rst_b_n = 1'b1;

  always #5 clk = ~clk;

  multicycle_controller_if #(.CNT_W(4))  bus_a();
  multicycle_controller_if #(.CNT_W(16)) bus_b();

  multicycle_controller #(.MEM_HANDSHAKE(1'b1), .SUPPORT_JAL(1'b1), .CNT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_a_n), .io_bus(bus_a));
  multicycle_controller #(.MEM_HANDSHAKE(1'b0), .SUPPORT_JAL(1'b0), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_b_n), .io_bus(bus_b));

  typedef struct {
    logic [6:0]  op;
    logic        z;
    int          fw;     // wait cycles in FETCH
    int          dw;     // wait cycles in MEMREAD/MEMWRITE
    int          base;   // zero-wait cycle count
    logic [31:0] trace;  // non-FETCH states visited, one nibble each
    int          ret;
    int          ill;
  } vec_t;

  typedef struct {
    logic [31:0] trace;
    int          len;
    int          ret;
    int          ill;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[9];

  int n_vec  = 0;
  int n_miss = 0;

  logic [3:0]  prev_st  = 4'd0;
  logic [31:0] obs_tr   = 32'd0;
  int          obs_cyc  = 0;
  int          obs_done = 0;
  int          obs_ill  = 0;
  logic [3:0]  exp_cnt  = 4'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // {PCWrite,AdrSrc,MemRead,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,RegWrite,Branch,instr_done,illegal_op}
  function automatic logic [16:0] exp_ctrl(input logic [3:0] st, input logic rdy,
                                           input logic z, input logic [6:0] op, input bit jal_ok);
    logic pc, adr, mr, mw, ir, rw, br, done, ill;
    logic [1:0] rs, sa, sb, aop;
    pc = 0; adr = 0; mr = 0; mw = 0; ir = 0; rw = 0; br = 0; done = 0; ill = 0;
    rs = 2'b00; sa = 2'b00; sb = 2'b00; aop = 2'b00;
    case (st)
      4'd0:  begin mr = 1; sb = 2'b10; rs = 2'b10; ir = rdy; pc = rdy; end
      4'd1:  begin
        sa = 2'b01; sb = 2'b01;
        ill = !(op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 ||
                op == 7'b0010011 || op == 7'b1100011 || (jal_ok && op == 7'b1101111));
      end
      4'd2:  begin sa = 2'b10; sb = 2'b01; end
      4'd3:  begin adr = 1; mr = 1; end
      4'd4:  begin rs = 2'b01; rw = 1; done = 1; end
      4'd5:  begin adr = 1; mw = 1; done = rdy; end
      4'd6:  begin sa = 2'b10; sb = 2'b00; aop = 2'b10; end
      4'd7:  begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
      4'd8:  begin rw = 1; done = 1; end
      4'd9:  begin sa = 2'b10; aop = 2'b01; br = 1; pc = z; done = 1; end
      4'd10: begin sa = 2'b01; sb = 2'b10; pc = 1; end
      default: ;
    endcase
    return {pc, adr, mr, mw, ir, rs, sa, sb, aop, rw, br, done, ill};
  endfunction

  task automatic sample_a();
    logic [16:0] act;
    exp_t e;
    act = {bus_a.PCWrite, bus_a.AdrSrc, bus_a.MemRead, bus_a.MemWrite, bus_a.IRWrite,
           bus_a.ResultSrc, bus_a.ALUSrcA, bus_a.ALUSrcB, bus_a.ALUOp, bus_a.RegWrite,
           bus_a.Branch, bus_a.instr_done, bus_a.illegal_op};
    chk($sformatf("ctrl_st%0d", bus_a.state), 32'(act),
        32'(exp_ctrl(bus_a.state, bus_a.mem_ready, bus_a.zero, bus_a.opcode, 1'b1)));
    if (bus_a.state == 4'd0 && prev_st != 4'd0) begin
      if (sbq.size() == 0) begin
        chk("sb_unexpected_instr", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("sb_trace", obs_tr, e.trace);
        chk("sb_cycles", 32'(obs_cyc), 32'(e.len));
        chk("sb_done_pulses", 32'(obs_done), 32'(e.ret));
        chk("sb_illegal_pulses", 32'(obs_ill), 32'(e.ill));
        exp_cnt = exp_cnt + 4'(e.ret);
        chk("sb_retired_cnt", 32'(bus_a.retired_cnt), 32'(exp_cnt));
      end
      obs_tr = 32'd0; obs_cyc = 0; obs_done = 0; obs_ill = 0;
    end
    obs_cyc++;
    if (bus_a.state != prev_st && bus_a.state != 4'd0) obs_tr = (obs_tr << 4) | 32'(bus_a.state);
    obs_done += int'(bus_a.instr_done);
    obs_ill  += int'(bus_a.illegal_op);
    prev_st = bus_a.state;
  endtask

  // Drives one instruction on A; returns #1 into the following FETCH cycle
  task automatic run_vec(input vec_t v);
    exp_t e;
    e.trace = v.trace; e.len = v.base + v.fw + v.dw; e.ret = v.ret; e.ill = v.ill;
    sbq.push_back(e);
    bus_a.opcode = v.op;
    bus_a.zero   = v.z;
    for (int k = 0; k < e.len; k++) begin
      bus_a.mem_ready = !((k < v.fw) || (k >= v.fw + 3 && k < v.fw + 3 + v.dw));
      @(negedge clk);
      sample_a();
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv;
    vecs[0] = '{7'b0110011, 1'b0, 0, 0, 4, 32'h168,  1, 0};
    vecs[1] = '{7'b0000011, 1'b0, 0, 2, 5, 32'h1234, 1, 0};
    vecs[2] = '{7'b1100011, 1'b1, 0, 0, 3, 32'h19,   1, 0};
    vecs[3] = '{7'b1100011, 1'b0, 1, 0, 3, 32'h19,   1, 0};
    vecs[4] = '{7'b1111111, 1'b0, 0, 0, 2, 32'h1,    0, 1};
    vecs[5] = '{7'b1101111, 1'b1, 0, 0, 4, 32'h1A8,  1, 0};
    vecs[6] = '{7'b0010011, 1'b0, 2, 0, 4, 32'h178,  1, 0};
    vecs[7] = '{7'b0100011, 1'b0, 1, 2, 4, 32'h125,  1, 0};
    vecs[8] = '{7'b0000011, 1'b0, 3, 0, 5, 32'h1234, 1, 0};

    bus_a.opcode = 7'b0110011; bus_a.zero = 1'b0; bus_a.mem_ready = 1'b1;
    bus_b.opcode = 7'b1101111; bus_b.zero = 1'b0; bus_b.mem_ready = 1'b0;

    #2;
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    #1;
    chk("rst_a_state", 32'(bus_a.state), 32'd0);
    chk("rst_a_cnt", 32'(bus_a.retired_cnt), 32'd0);
    chk("rst_a_memread", 32'(bus_a.MemRead), 32'd0);
    chk("rst_a_irwrite", 32'(bus_a.IRWrite), 32'd0);
    chk("rst_a_pcwrite", 32'(bus_a.PCWrite), 32'd0);
    chk("rst_a_alusrcb", 32'(bus_a.ALUSrcB), 32'd0);
    chk("rst_b_state", 32'(bus_b.state), 32'd0);

    // DUT B: JAL is illegal, and mem_ready is ignored
    @(posedge clk); #1;
    rst_b_n = 1'b1;
    chk("b_fetch_state", 32'(bus_b.state), 32'd0);
    chk("b_fetch_memread", 32'(bus_b.MemRead), 32'd1);
    chk("b_fetch_irwrite_noready", 32'(bus_b.IRWrite), 32'd1);
    chk("b_fetch_pcwrite_noready", 32'(bus_b.PCWrite), 32'd1);
    @(posedge clk); #1;
    chk("b_jal_decode_state", 32'(bus_b.state), 32'd1);
    chk("b_jal_illegal", 32'(bus_b.illegal_op), 32'd1);
    chk("b_jal_no_done", 32'(bus_b.instr_done), 32'd0);
    @(posedge clk); #1;
    chk("b_jal_back_fetch", 32'(bus_b.state), 32'd0);
    chk("b_illegal_one_cycle", 32'(bus_b.illegal_op), 32'd0);
    chk("b_cnt_after_illegal", 32'(bus_b.retired_cnt), 32'd0);
    bus_b.opcode = 7'b0100011;
    @(posedge clk); #1;
    chk("b_st_decode", 32'(bus_b.state), 32'd1);
    @(posedge clk); #1;
    chk("b_st_memadr", 32'(bus_b.state), 32'd2);
    @(posedge clk); #1;
    chk("b_st_memwrite", 32'(bus_b.state), 32'd5);
    chk("b_st_memwrite_strobe", 32'(bus_b.MemWrite), 32'd1);
    chk("b_st_done_noready", 32'(bus_b.instr_done), 32'd1);
    @(posedge clk); #1;
    chk("b_st_back_fetch", 32'(bus_b.state), 32'd0);
    chk("b_st_cnt", 32'(bus_b.retired_cnt), 32'd1);
    chk("a_held_in_reset", 32'(bus_a.state), 32'd0);

    // DUT A: table of instructions through the scoreboard
    @(posedge clk); #1;
    rst_a_n = 1'b1;
    foreach (vecs[i]) run_vec(vecs[i]);
    bus_a.opcode = 7'b0100011;
    bus_a.mem_ready = 1'b1;
    @(negedge clk);
    sample_a();
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    // Store abandoned by reset while waiting in MEMWRITE
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus_a.mem_ready = 1'b0;
    #1;
    chk("a_st_in_memwrite", 32'(bus_a.state), 32'd5);
    chk("a_st_memwrite_held", 32'(bus_a.MemWrite), 32'd1);
    chk("a_st_no_done_waiting", 32'(bus_a.instr_done), 32'd0);
    rst_a_n = 1'b0;
    #1;
    chk("a_midrst_memwrite", 32'(bus_a.MemWrite), 32'd0);
    chk("a_midrst_state", 32'(bus_a.state), 32'd0);
    chk("a_midrst_cnt", 32'(bus_a.retired_cnt), 32'd0);
    chk("a_midrst_memread", 32'(bus_a.MemRead), 32'd0);
    @(posedge clk); #1;
    chk("a_midrst_regwrite", 32'(bus_a.RegWrite), 32'd0);
    chk("a_midrst_cnt_held", 32'(bus_a.retired_cnt), 32'd0);

    // 17 R-type instructions wrap the 4-bit counter to 1
    prev_st = 4'd0; obs_tr = 32'd0; obs_cyc = 0; obs_done = 0; obs_ill = 0; exp_cnt = 4'd0;
    rst_a_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      rv = '{7'b0110011, 1'(i % 2), i % 3, 0, 4, 32'h168, 1, 0};
      run_vec(rv);
    end
    @(negedge clk);
    sample_a();
    chk("wrap_final_cnt", 32'(bus_a.retired_cnt), 32'd1);
    chk("sb_drained_wrap", 32'(sbq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
